fib_index_finder: RTL

- Inverse of the team's Fibonacci sequence generator: the generator maps an index to a value; this block maps a 32-bit value to its index.
- Accepts a 32-bit value over a valid/ready handshake.
- Iterates the series F(0)=0, F(1)=1, F(k+1)=F(k)+F(k-1) one term per cycle.
- Reports whether the value is a Fibonacci number and its index, over a valid/ready output handshake.
- Sits downstream of the generator as a checker or index decoder for the Fibonacci datapath.

---
 rtl/fib_index_finder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fib_index_finder.sv
// Fibonacci index finder: classifies a 32-bit unsigned value against the
// Fibonacci series F(0)=0, F(1)=1, ... and reports its index.
//
// The series is walked one term per cycle from F(0), so the search stops at
// the first term that is equal to or greater than the target. A value that
// appears twice in the series (1 = F(1) = F(2)) therefore reports the
// smaller index.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_value   value to classify (unsigned)
//   in_ready   block can accept a request (IDLE)
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   out_is_fib 1 if in_value equals some F(k)
//   out_index  matching index, else first index with F(k) > value (48 past F(47))
//   busy       high while searching
module fib_index_finder #(
  parameter int unsigned MAX_IDX = 47
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_value,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_fib,
  output logic [5:0]  out_index,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;          // F(k)
  logic [31:0] b_q, b_d;          // F(k+1)
  logic [5:0]  k_q, k_d;
  logic [31:0] target_q, target_d;
  logic        is_fib_q, is_fib_d;
  logic [5:0]  index_q, index_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= 32'd0;
      b_q      <= 32'd1;
      k_q      <= 6'd0;
      target_q <= 32'd0;
      is_fib_q <= 1'b0;
      index_q  <= 6'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      target_q <= target_d;
      is_fib_q <= is_fib_d;
      index_q  <= index_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    target_d = target_q;
    is_fib_d = is_fib_q;
    index_d  = index_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          target_d = in_value;
          a_d      = 32'd0;
          b_d      = 32'd1;
          k_d      = 6'd0;
          state_d  = StSearch;
        end
      end
      StSearch: begin
        if (a_q == target_q) begin
          is_fib_d = 1'b1;
          index_d  = k_q;
          state_d  = StDone;
        end else if (a_q > target_q) begin
          is_fib_d = 1'b0;
          index_d  = k_q;
          state_d  = StDone;
        end else if (k_q == 6'(MAX_IDX)) begin
          is_fib_d = 1'b0;
          index_d  = 6'(MAX_IDX + 1);
          state_d  = StDone;
        end else begin
          // b wraps only on the step into MAX_IDX; that value is never compared.
          a_d = b_q;
          b_d = a_q + b_q;
          k_d = k_q + 6'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q == StSearch);
  assign out_valid  = (state_q == StDone);
  assign out_is_fib = is_fib_q;
  assign out_index  = index_q;

endmodule
